// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake plus the shared-ALU control/operand bundle.
// The sequencer takes the slave modport; requester, consumer and ALU sit behind master.
interface alu_op_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_taken;

    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [4:0]      alu_funct_select;
    logic [XLEN-1:0] alu_out;
    logic            alu_z;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_z,
        output req_ready, rsp_valid, rsp_result, rsp_taken,
               alu_in1, alu_in2, alu_funct_select
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_z,
        input  req_ready, rsp_valid, rsp_result, rsp_taken,
               alu_in1, alu_in2, alu_funct_select
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle RV32I op sequencer driving a shared shifter-less ALU; one op in flight.
// Latency 2 (non-shift), 1 (shamt 0), 1+shamt (shift); response held in DONE until rsp_ready.
module alu_op_sequencer #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLTU, OP_SLT, OP_SLL,
        OP_SRL, OP_SRA, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
    } op_t;

    typedef struct packed {
        op_t             op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } req_t;

    function automatic logic [4:0] exec_sel(input op_t op);
        case (op)
            OP_SUB, OP_BEQ, OP_BNE:     exec_sel = 5'b10000;
            OP_XOR:                     exec_sel = 5'b00001;
            OP_OR:                      exec_sel = 5'b00010;
            OP_AND:                     exec_sel = 5'b00011;
            OP_SLTU, OP_BLTU, OP_BGEU:  exec_sel = 5'b00100;
            OP_SLT, OP_BLT, OP_BGE:     exec_sel = 5'b00101;
            default:                    exec_sel = 5'b00000;
        endcase
    endfunction

    function automatic logic is_shift(input op_t op);
        is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    state_t               state_q;
    req_t                 req_q;
    logic [XLEN-1:0]      acc_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic                 rsp_valid_q;
    logic [XLEN-1:0]      rsp_result_q;
    logic                 rsp_taken_q;

    logic [XLEN-1:0]      acc_d;
    logic                 taken_d;
    logic [XLEN-1:0]      exec_result_d;
    logic [XLEN-1:0]      alu_in1_d;
    logic [XLEN-1:0]      alu_in2_d;
    logic [4:0]           alu_sel_d;
    op_t                  req_op_in;
    logic [SHAMT_W-1:0]   req_shamt;

    assign req_op_in = op_t'(bus.req_op);
    assign req_shamt = bus.req_b[SHAMT_W-1:0];

    // ALU is only steered in EXEC and SLL steps; forced idle while reset is held.
    always_comb begin
        alu_in1_d = '0;
        alu_in2_d = '0;
        alu_sel_d = 5'b00000;
        if (!rst) begin
            case (state_q)
                EXEC: begin
                    alu_in1_d = req_q.a;
                    alu_in2_d = req_q.b;
                    alu_sel_d = exec_sel(req_q.op);
                end
                SHIFT: begin
                    if (req_q.op == OP_SLL) begin
                        alu_in1_d = acc_q;
                        alu_in2_d = acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (req_q.op)
            OP_SLL:  acc_d = bus.alu_out;
            OP_SRA:  acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_d = {1'b0, acc_q[XLEN-1:1]};
        endcase
    end

    // Less-than compares arrive as bit 0 of the SLT/SLTU result; equality uses the zero flag.
    always_comb begin
        case (req_q.op)
            OP_BEQ:           taken_d = bus.alu_z;
            OP_BNE:           taken_d = !bus.alu_z;
            OP_BLT, OP_BLTU:  taken_d = bus.alu_out[0];
            OP_BGE, OP_BGEU:  taken_d = !bus.alu_out[0];
            default:          taken_d = 1'b0;
        endcase
        exec_result_d = (req_q.op >= OP_BEQ) ? {{(XLEN-1){1'b0}}, taken_d} : bus.alu_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_taken_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q.op <= req_op_in;
                        req_q.a  <= bus.req_a;
                        req_q.b  <= bus.req_b;
                        cnt_q    <= req_shamt;
                        if (!is_shift(req_op_in)) begin
                            state_q <= EXEC;
                        end else if (req_shamt == '0) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_result_q <= bus.req_a;
                            rsp_taken_q  <= 1'b0;
                            state_q      <= DONE;
                        end else begin
                            acc_q   <= bus.req_a;
                            state_q <= SHIFT;
                        end
                    end
                end
                EXEC: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_result_q <= exec_result_d;
                    rsp_taken_q  <= taken_d;
                    state_q      <= DONE;
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= acc_d;
                        rsp_taken_q  <= 1'b0;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready        = !rst && (state_q == IDLE);
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_result       = rsp_result_q;
    assign bus.rsp_taken        = rsp_taken_q;
    assign bus.alu_in1          = alu_in1_d;
    assign bus.alu_in2          = alu_in2_d;
    assign bus.alu_funct_select = alu_sel_d;

endmodule
